// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes seen by the writeback stage, its state
// encoding and the architectural reset values of the status and stack registers.
package cpu_pkg;

  localparam logic [5:0] OP_MUL = 6'b101010;
  localparam logic [5:0] OP_RTN = 6'b100110;

  localparam logic [11:0] STACK_RESET_DEF  = 12'hFFF;
  localparam logic [7:0]  STATUS_RESET_DEF = 8'h00;

  typedef enum logic {
    IDLE   = 1'b0,
    MUL_HI = 1'b1
  } wb_state_e;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback bundle: result handshake, register-file write port and the
// status/stack feedback that returns to the ALU.
interface alu_writeback_if;

  logic        in_valid;
  logic        in_ready;
  logic [5:0]  encoded_opcode;
  logic        reg_we_req;
  logic [2:0]  reg_write_addr;
  logic [15:0] aluout1;
  logic [15:0] aluout2;
  logic [7:0]  statusregout;
  logic [11:0] decremented_stack_reg;
  logic        hold;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  statusreg;
  logic [11:0] stack_reg;
  logic        mul_busy;

  modport master (
    output in_valid, encoded_opcode, reg_we_req, reg_write_addr,
           aluout1, aluout2, statusregout, decremented_stack_reg, hold,
    input  in_ready, rf_we, rf_waddr, rf_wdata, statusreg, stack_reg, mul_busy
  );

  modport slave (
    input  in_valid, encoded_opcode, reg_we_req, reg_write_addr,
           aluout1, aluout2, statusregout, decremented_stack_reg, hold,
    output in_ready, rf_we, rf_waddr, rf_wdata, statusreg, stack_reg, mul_busy
  );

endinterface

// File: rtl/alu_writeback.sv
// Registered writeback stage: drives the register-file write port, owns the
// status register and stack pointer, and splits MUL results into two writes.
module alu_writeback #(
  parameter logic [11:0] STACK_RESET  = cpu_pkg::STACK_RESET_DEF,
  parameter logic [7:0]  STATUS_RESET = cpu_pkg::STATUS_RESET_DEF
) (
  input logic            clk,
  input logic            reset,
  alu_writeback_if.slave bus
);
  import cpu_pkg::*;

  wb_state_e   state_q, state_d;
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_waddr_q, rf_waddr_d;
  logic [15:0] rf_wdata_q, rf_wdata_d;
  logic [7:0]  status_q, status_d;
  logic [11:0] stack_q, stack_d;
  logic [15:0] hi_data_q, hi_data_d;
  logic [2:0]  hi_addr_q, hi_addr_d;
  logic        mul_busy_q, mul_busy_d;
  logic        in_ready;
  logic        accept;

  assign in_ready = (state_q == IDLE) && !bus.hold && !reset;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    status_d   = status_q;
    stack_d    = stack_q;
    hi_data_d  = hi_data_q;
    hi_addr_d  = hi_addr_q;
    mul_busy_d = mul_busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rf_waddr_d = bus.reg_write_addr;
          rf_wdata_d = bus.aluout1;
          status_d   = bus.statusregout;
          if (bus.encoded_opcode == OP_MUL) begin
            // The high half always lands in the next register, wrapping R7 to R0.
            rf_we_d    = 1'b1;
            hi_data_d  = bus.aluout2;
            hi_addr_d  = bus.reg_write_addr + 3'd1;
            mul_busy_d = 1'b1;
            state_d    = MUL_HI;
          end else begin
            rf_we_d = bus.reg_we_req;
            if (bus.encoded_opcode == OP_RTN) begin
              stack_d = bus.decremented_stack_reg;
            end
          end
        end
      end
      MUL_HI: begin
        if (!bus.hold) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = hi_addr_q;
          rf_wdata_d = hi_data_q;
          mul_busy_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 3'd0;
      rf_wdata_q <= 16'd0;
      status_q   <= STATUS_RESET;
      stack_q    <= STACK_RESET;
      hi_data_q  <= 16'd0;
      hi_addr_q  <= 3'd0;
      mul_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      status_q   <= status_d;
      stack_q    <= stack_d;
      hi_data_q  <= hi_data_d;
      hi_addr_q  <= hi_addr_d;
      mul_busy_q <= mul_busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.statusreg = status_q;
  assign bus.stack_reg = stack_q;
  assign bus.mul_busy  = mul_busy_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: a reference model predicts every register
// write and the status/stack/handshake state, a monitor compares on each negedge.
module tb_alu_writeback;
  import cpu_pkg::*;

  localparam logic [5:0] OP_ADD = 6'b010001;
  localparam logic [5:0] OP_INC = 6'b000011;
  localparam logic [5:0] OP_GHS = 6'b000000;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        busy;
  } wr_t;

  logic clk;
  logic reset;
  alu_writeback_if bus ();

  alu_writeback #(.STACK_RESET(12'hFFF), .STATUS_RESET(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, advanced on every rising edge.
  wr_t         exp_q[$];
  int unsigned cyc = 0;
  logic [7:0]  m_status = 8'h00;
  logic [11:0] m_stack  = 12'hFFF;
  bit          m_pending = 1'b0;
  logic [2:0]  m_hi_addr = 3'd0;
  logic [15:0] m_hi_data = 16'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic hold, input logic [5:0] op,
                               input logic we, input logic [2:0] addr,
                               input logic [15:0] a1, input logic [15:0] a2,
                               input logic [7:0] st, input logic [11:0] dec);
    bus.in_valid              = valid;
    bus.hold                  = hold;
    bus.encoded_opcode        = op;
    bus.reg_we_req            = we;
    bus.reg_write_addr        = addr;
    bus.aluout1               = a1;
    bus.aluout2               = a2;
    bus.statusregout          = st;
    bus.decremented_stack_reg = dec;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, OP_GHS, 1'b0, 3'd0, 16'd0, 16'd0, 8'd0, 12'd0);
  endtask

  // Model: what a writeback stage must do with whatever it is handed this edge.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_status  = 8'h00;
        m_stack   = 12'hFFF;
        m_pending = 1'b0;
      end else begin
        cyc++;
        if (m_pending) begin
          if (!bus.hold) begin
            exp_q.push_back('{cyc, m_hi_addr, m_hi_data, 1'b0});
            m_pending = 1'b0;
          end
        end else if (bus.in_valid && !bus.hold) begin
          m_status = bus.statusregout;
          if (bus.encoded_opcode == OP_MUL) begin
            exp_q.push_back('{cyc, bus.reg_write_addr, bus.aluout1, 1'b1});
            m_hi_addr = 3'((int'(bus.reg_write_addr) + 1) % 8);
            m_hi_data = bus.aluout2;
            m_pending = 1'b1;
          end else begin
            if (bus.encoded_opcode == OP_RTN) m_stack = bus.decremented_stack_reg;
            if (bus.reg_we_req) exp_q.push_back('{cyc, bus.reg_write_addr, bus.aluout1, 1'b0});
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        w = exp_q.pop_front();
        checkOutput("missed_write", 32'(bus.rf_we), 32'd1);
      end
      if (bus.rf_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_write", 32'(bus.rf_we), 32'd0);
        end else begin
          w = exp_q.pop_front();
          checkOutput("write_cycle", cyc, w.cyc);
          checkOutput("rf_waddr", 32'(bus.rf_waddr), 32'(w.addr));
          checkOutput("rf_wdata", 32'(bus.rf_wdata), 32'(w.data));
          checkOutput("write_mul_busy", 32'(bus.mul_busy), 32'(w.busy));
        end
      end
      checkOutput("statusreg", 32'(bus.statusreg), 32'(m_status));
      checkOutput("stack_reg", 32'(bus.stack_reg), 32'(m_stack));
      checkOutput("mul_busy", 32'(bus.mul_busy), 32'(m_pending));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!reset && !m_pending && !bus.hold));
    end
  end

  initial begin
    logic [5:0] op;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, OP_GHS, 1'b0, 3'd0, 16'd0, 16'd0, 8'd0, 12'd0);
    idleCycles(1);
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] ADD then idle");
    applyStimulus(1'b1, 1'b0, OP_ADD, 1'b1, 3'd3, 16'h1234, 16'h0, 8'h02, 12'h000);
    idleCycles(2);

    $display("[TB] MUL with address wrap");
    applyStimulus(1'b1, 1'b0, OP_MUL, 1'b1, 3'd7, 16'hBEEF, 16'hDEAD, 8'h05, 12'h000);
    idleCycles(2);

    $display("[TB] MUL stalled by hold");
    applyStimulus(1'b1, 1'b0, OP_MUL, 1'b1, 3'd2, 16'h1111, 16'h2222, 8'h09, 12'h000);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, OP_ADD, 1'b1, 3'd5, 16'h5555, 16'h0, 8'h77, 12'h000);
    idleCycles(2);

    $display("[TB] RTN then INC");
    applyStimulus(1'b1, 1'b0, OP_RTN, 1'b0, 3'd0, 16'h0, 16'h0, 8'h10, 12'hFFE);
    applyStimulus(1'b1, 1'b0, OP_INC, 1'b1, 3'd4, 16'h0042, 16'h0, 8'h11, 12'h000);
    idleCycles(1);

    $display("[TB] ghost op and back-to-back ADDs");
    applyStimulus(1'b1, 1'b0, OP_GHS, 1'b0, 3'd6, 16'hAAAA, 16'h0, 8'h80, 12'h123);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, OP_ADD, 1'b1, 3'(i + 1), 16'(16'h0100 + i), 16'h0, 8'(8'h20 + i), 12'h000);
    idleCycles(2);

    $display("[TB] reset during pending MUL high half");
    applyStimulus(1'b1, 1'b0, OP_MUL, 1'b1, 3'd1, 16'hCAFE, 16'hF00D, 8'h33, 12'h000);
    applyStimulus(1'b0, 1'b1, OP_GHS, 1'b0, 3'd0, 16'h0, 16'h0, 8'h00, 12'h000);
    reset = 1'b1;
    #1;
    checkOutput("reset_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("reset_statusreg", 32'(bus.statusreg), 32'h00);
    checkOutput("reset_stack_reg", 32'(bus.stack_reg), 32'hFFF);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_mul_busy", 32'(bus.mul_busy), 32'd0);
    applyStimulus(1'b0, 1'b0, OP_GHS, 1'b0, 3'd0, 16'h0, 16'h0, 8'h00, 12'h000);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    idleCycles(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_MUL;
        1:       op = OP_RTN;
        default: op = 6'($urandom);
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), op,
                    1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                    8'($urandom), 12'($urandom));
    end
    idleCycles(4);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Registered writeback stage directly downstream of the combinational ALU. It captures the ALU results (aluout1/aluout2, statusregout, decremented_stack_reg) and drives the single register-file write port. It owns the architectural status register and the 12-bit stack pointer, which feed back into the ALU's statusregin/stack_reg inputs. It serialises the 32-bit MUL result into two register writes, stalling upstream with a valid/ready handshake.

Parameters:
STACK_RESET, 12'hFFF, stack pointer value after reset.
STATUS_RESET, 8'h00, status register value after reset.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  ALU result for the current instruction is valid this cycle
in_ready  output  1  stage can accept a result this cycle
encoded_opcode  input  6  opcode of the instruction whose result is presented
reg_we_req  input  1  decoder flag: instruction writes its destination register
reg_write_addr  input  3  destination register address
aluout1  input  16  ALU primary result (MUL low half)
aluout2  input  16  MUL high half
statusregout  input  8  next status value computed by ALU
decremented_stack_reg  input  12  next stack pointer computed by ALU
hold  input  1  downstream/memory stall; freezes this stage
rf_we  output  1  register-file write enable
rf_waddr  output  3  register-file write address
rf_wdata  output  16  register-file write data
statusreg  output  8  architectural status register (to ALU statusregin)
stack_reg  output  12  architectural stack pointer (to ALU stack_reg)
mul_busy  output  1  high while the MUL high-half write is pending

Behaviour:
- Reset (async, immediate): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, mul_busy=0, statusreg=STATUS_RESET, stack_reg=STACK_RESET. in_ready = 0 while reset is high.
- All outputs registered. Latency is 1 cycle: a result accepted at edge N appears on rf_* at N+1.
- Accept condition: in_valid & in_ready. in_ready = (state==IDLE) & ~hold & ~reset.
- FSM states: IDLE, MUL_HI.
- IDLE, accept, opcode != OP_MUL:
  - rf_we <= reg_we_req; rf_waddr <= reg_write_addr; rf_wdata <= aluout1.
  - statusreg <= statusregout. All opcodes update it; ghost ops and flag set/clear ops already arrive correct from the ALU.
  - stack_reg <= decremented_stack_reg only when opcode == OP_RTN; otherwise it is held.
  - Remain in IDLE.
- IDLE, accept, opcode == OP_MUL:
  - rf_we <= 1; rf_waddr <= reg_write_addr; rf_wdata <= aluout1.
  - statusreg <= statusregout.
  - Internally latch hi_data <= aluout2 and hi_addr <= reg_write_addr+1, mod 8 (7 wraps to 0).
  - mul_busy <= 1; go to MUL_HI.
- MUL_HI, ~hold: rf_we <= 1; rf_waddr <= hi_addr; rf_wdata <= hi_data; mul_busy <= 0; go to IDLE. in_ready is 0 throughout MUL_HI, so no result is accepted that cycle.
- No accept (in_valid=0, or hold=1 in IDLE): rf_we <= 0. rf_waddr and rf_wdata hold their values. statusreg and stack_reg hold.
- hold=1 in MUL_HI: state, hi_data, hi_addr and mul_busy are frozen, and rf_we <= 0. The high-half write issues on the first cycle with hold=0.
- Back-to-back: single-cycle ops accept every cycle; each produces a one-cycle rf_we pulse.
- in_valid while in_ready=0: input is ignored. Upstream holds its result until it is accepted.
- Reset mid-MUL: the pending high-half write is discarded and there is no partial write.

Decomposition:
- Shared package cpu_pkg holds:
  - OP_MUL=6'b101010 and OP_RTN=6'b100110.
  - Writeback state encoding (IDLE=1'b0, MUL_HI=1'b1).
  - Reset constants STACK_RESET and STATUS_RESET.
- No sub-module is required. The FSM plus the status and stack registers form one flat module.

Test Plan:
- Reset: assert reset mid-run -> immediately rf_we=0, statusreg=8'h00, stack_reg=12'hFFF, in_ready=0. Deassert -> in_ready=1.
- ADD result: opcode 6'b010001, reg_we_req=1, addr=3, aluout1=16'h1234, statusregout=8'h02 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, statusreg=8'h02. The following idle cycle has rf_we=0.
- MUL with wrap: opcode OP_MUL, addr=7, aluout1=16'hBEEF, aluout2=16'hDEAD -> cycle+1 writes R7=BEEF with mul_busy=1 and in_ready=0. Cycle+2 writes R0=DEAD and mul_busy=0.
- MUL under hold: hold=1 for 3 cycles right after the low-half write -> rf_we=0 and mul_busy=1 for those 3 cycles, then R[addr+1] is written once hold drops.
- RTN vs other: RTN with decremented_stack_reg=12'hFFE -> stack_reg=12'hFFE. A following INC with decremented_stack_reg=12'h000 -> stack_reg stays 12'hFFE.
- Ghost op and back-to-back: GHS with reg_we_req=0 -> rf_we=0 and statusreg updated. Three consecutive valid ADDs -> three consecutive rf_we pulses with in_ready held at 1.
